// File: rtl/rf_wb_arbiter.sv
// Two-port writeback arbiter for the single register-file write port.
// Port 0 (pipeline) has fixed priority; port 1 (mul/div) is boosted after repeated losses.
module rf_wb_arbiter #(
  parameter int CREG_NUM   = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hold,
  input  logic                        req0_valid,
  input  logic [$clog2(CREG_NUM)-1:0] req0_id,
  input  logic [DATA_W-1:0]           req0_data,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [$clog2(CREG_NUM)-1:0] req1_id,
  input  logic [DATA_W-1:0]           req1_data,
  output logic                        req1_ready,
  output logic                        rfwrite_valid,
  output logic [$clog2(CREG_NUM)-1:0] rfwrite_id,
  output logic [DATA_W-1:0]           rfwrite_data,
  output logic                        boost
);

  localparam int ID_W = $clog2(CREG_NUM);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt;
  logic [2:0] starve_cnt_nxt;
  logic       grant0;
  logic       grant1;
  logic       wr_en_nxt;

  // Handshake: a transfer on port n happens in a cycle with reqn_valid && reqn_ready.
  // Ready depends only on reset, hold, both valids and the boost state -- never on id/data.
  assign boost  = (starve_cnt == STARVE_LIM);
  assign grant1 = !reset && !hold && req1_valid && (boost || !req0_valid);
  assign grant0 = !reset && !hold && req0_valid && !(boost && req1_valid);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Id 0 is the hardwired zero register: accepted, but never written.
  assign wr_en_nxt = (grant0 && (req0_id != '0)) || (grant1 && (req1_id != '0));

  // hold freezes the counter even when port 1 has dropped its request.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!hold) begin
      if (grant1 || !req1_valid) begin
        starve_cnt_nxt = '0;
      end else if (starve_cnt < STARVE_LIM) begin
        starve_cnt_nxt = starve_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rfwrite_valid <= 1'b0;
      rfwrite_id    <= '0;
      rfwrite_data  <= '0;
      starve_cnt    <= '0;
    end else begin
      rfwrite_valid <= wr_en_nxt;
      starve_cnt    <= starve_cnt_nxt;
      if (grant0) begin
        rfwrite_id   <= req0_id;
        rfwrite_data <= req0_data;
      end else if (grant1) begin
        rfwrite_id   <= req1_id;
        rfwrite_data <= req1_data;
      end
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters:
  - port 0: the main pipeline writeback stage.
  - port 1: the multi-cycle mul/div unit.
- Grants one request per cycle using fixed priority (port 0 first) plus an anti-starvation boost for port 1.
- Registers the winning write and drives it onto the regfile write port (valid, id, data) one cycle after the grant.

Parameters:
- CREG_NUM, 32, number of architectural registers; id width is log2(CREG_NUM).
- DATA_W, 32, write data width.
- STARVE_MAX, 3, consecutive lost cycles after which port 1 is boosted; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  when 1, no grant is issued this cycle.
- req0_valid  in  1  port 0 write request.
- req0_id  in  log2(CREG_NUM)  port 0 destination register.
- req0_data  in  DATA_W  port 0 write data.
- req0_ready  out  1  port 0 granted this cycle (combinational).
- req1_valid  in  1  port 1 write request.
- req1_id  in  log2(CREG_NUM)  port 1 destination register.
- req1_data  in  DATA_W  port 1 write data.
- req1_ready  out  1  port 1 granted this cycle (combinational).
- rfwrite_valid  out  1  registered write enable to the regfile.
- rfwrite_id  out  log2(CREG_NUM)  registered write register id.
- rfwrite_data  out  DATA_W  registered write data.
- boost  out  1  port 1 currently has priority (debug/perf).

Behaviour:
- Clocking and reset:
  - One clock, clk. reset is asynchronous, active-high.
  - While reset is 1: rfwrite_valid=0, rfwrite_id=0, rfwrite_data=0, starve_cnt=0, boost=0.
  - req*_ready are combinational; they are 0 whenever reset=1.
- Handshake:
  - A transfer on port n occurs in a cycle where reqn_valid=1 and reqn_ready=1.
  - A requester holds valid, id and data stable until it is accepted.
  - ready never depends on the id or data of the same port.
- Grant logic (combinational, at most one grant per cycle):
  - hold=1 -> no grant.
  - Otherwise, boost=1 and req1_valid=1 -> grant port 1.
  - Otherwise, req0_valid=1 -> grant port 0.
  - Otherwise, req1_valid=1 -> grant port 1.
  - Otherwise, no grant.
- Output register, updated on the posedge after the grant:
  - rfwrite_valid <= granted and granted id != 0.
  - rfwrite_id and rfwrite_data <= the granted port's fields.
  - With no grant: rfwrite_valid <= 0, and id/data keep their previous values.
  - Writes to id 0 are accepted (ready=1) but never produce rfwrite_valid=1.
- Latency:
  - Exactly 1 cycle from accept to rfwrite_valid.
  - Throughput is 1 write per cycle; there is no internal queue.
- Starvation counter (starve_cnt, 3 bits, saturating):
  - req1_valid=1 and not granted and hold=0 -> starve_cnt <= min(starve_cnt+1, STARVE_MAX).
  - Port 1 granted, or req1_valid=0 -> starve_cnt <= 0.
  - hold=1 -> starve_cnt keeps its value.
  - boost = (starve_cnt == STARVE_MAX), a registered-state decode.
- Simultaneous events:
  - Both ports valid and boost=0 -> port 0 wins; port 1 waits.
  - Both ports valid with the same id -> the grant order above decides. The later-granted write lands later and overwrites, so the final value is from whichever port was granted last.
  - The boosted grant resets starve_cnt, so boost lasts exactly one grant.
- Reset mid-operation:
  - An asserted reset clears the output register immediately (asynchronously).
  - A pending un-accepted request is not lost; it is re-arbitrated after reset deasserts.

Test Plan:
- Reset and idle:
  - Stimulus: reset=1 for 3 cycles with req0_valid=1 and req1_valid=1.
  - Required: ready=0 on both ports, rfwrite_valid=0, boost=0.
  - Deassert reset: req0_ready=1 in that same cycle; next cycle rfwrite_valid=1 with port 0's id.
- Single write latency:
  - Stimulus: req0 id=5, data=0xDEADBEEF for one cycle.
  - Required: next cycle rfwrite_valid=1, rfwrite_id=5, rfwrite_data=0xDEADBEEF; the cycle after, rfwrite_valid=0.
- Starvation boost:
  - Stimulus: STARVE_MAX=3; req0_valid held 1 continuously; req1 (id=7, data=0x11) asserted.
  - Required: port 0 wins 3 cycles; boost=1 in the 4th; req1_ready=1 in that cycle; rfwrite shows id=7 the next cycle; boost=0 after.
- Writes to register 0:
  - Stimulus: req1 id=0, data=0xFFFFFFFF.
  - Required: req1_ready=1 and rfwrite_valid stays 0.
  - Stimulus: back-to-back req0 id=0, then id=3.
  - Required: only the id=3 write appears.
- hold:
  - Stimulus: hold=1 for 5 cycles with both ports valid and starve_cnt=2.
  - Required: no ready, rfwrite_valid=0, starve_cnt stays 2.
  - Release hold: port 0 is granted, starve_cnt=3, and the boost grant to port 1 occurs in the following cycle.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges while rfwrite_valid=1.
  - Required: rfwrite_valid drops to 0 before the next posedge, starve_cnt=0, and no write is issued on that edge.
